// File: rtl/edf_irq_sched.sv
// Earliest-deadline-first interrupt scheduler: stamps enabled rising edges with
// mtime + relative deadline and sweeps one line per cycle to present the earliest.
module edf_irq_sched #(
    parameter  int NrParIrqs = 4,
    localparam int IdWidth   = $clog2(NrParIrqs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic [31:0]          cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    input  logic [63:0]          mtime_i,
    input  logic [NrParIrqs-1:0] irq_i,
    input  logic                 claim_i,
    output logic                 irq_valid_o,
    output logic [IdWidth-1:0]   irq_id_o,
    output logic [63:0]          irq_deadline_o
);
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StScan = 1'b1;
    localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrParIrqs - 1);

    logic [31:0]          reldl_q [NrParIrqs];
    logic [31:0]          reldl_d [NrParIrqs];
    logic [63:0]          absdl_q [NrParIrqs];
    logic [63:0]          absdl_d [NrParIrqs];
    logic [NrParIrqs-1:0] en_q, en_d, irq_q, pending_q, pending_d;
    logic [0:0]           state_q, state_d;
    logic [IdWidth-1:0]   idx_q, idx_d, best_id_q, best_id_d, id_q, id_d;
    logic [63:0]          best_dl_q, best_dl_d, dl_q, dl_d;
    logic                 best_vld_q, best_vld_d, valid_q, valid_d;

    logic [NrParIrqs-1:0] edge_s, capture_s, claim_clr_s, dis_clr_s;
    logic                 claim_fire_s, restart_s, drop_s, cand_s;
    logic                 m_vld_s;
    logic [IdWidth-1:0]   m_id_s;
    logic [63:0]          m_dl_s;

    // Config writes, edge capture and pending-set bookkeeping
    always_comb begin
        reldl_d      = reldl_q;
        absdl_d      = absdl_q;
        en_d         = en_q;
        claim_clr_s  = '0;
        dis_clr_s    = '0;
        claim_fire_s = claim_i & valid_q;
        edge_s       = irq_i & ~irq_q & en_q;
        if (claim_fire_s) begin
            claim_clr_s[id_q] = 1'b1;
        end else begin
            claim_clr_s = '0;
        end
        // A claimed line may be re-captured in the same cycle: the capture wins.
        capture_s = edge_s & (~pending_q | claim_clr_s);
        for (int i = 0; i < NrParIrqs; i++) begin
            if (capture_s[i]) begin
                absdl_d[i] = mtime_i + {32'h0000_0000, reldl_q[i]};
            end else begin
                absdl_d[i] = absdl_q[i];
            end
        end
        if (cfg_req_i && (cfg_addr_i == 32'h0000_0100)) begin
            en_d      = cfg_wdata_i[NrParIrqs-1:0];
            dis_clr_s = ~cfg_wdata_i[NrParIrqs-1:0];
        end else if (cfg_req_i && (cfg_addr_i[1:0] == 2'b00)
                     && (cfg_addr_i < 32'(4 * NrParIrqs))) begin
            reldl_d[cfg_addr_i[IdWidth+1:2]] = cfg_wdata_i;
        end else begin
            en_d = en_q;
        end
        pending_d = ((pending_q & ~claim_clr_s) | capture_s) & ~dis_clr_s;
        restart_s = claim_fire_s | (|(pending_q & dis_clr_s));
        drop_s    = claim_fire_s | (valid_q & dis_clr_s[id_q]);
    end

    // Sweep FSM: one candidate per cycle, publish at the last index
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_vld_d = best_vld_q;
        best_id_d  = best_id_q;
        best_dl_d  = best_dl_q;
        valid_d    = valid_q;
        id_d       = id_q;
        dl_d       = dl_q;
        cand_s     = pending_q[idx_q] && (!best_vld_q || (absdl_q[idx_q] < best_dl_q));
        m_vld_s    = best_vld_q | cand_s;
        m_id_s     = cand_s ? idx_q : best_id_q;
        m_dl_s     = cand_s ? absdl_q[idx_q] : best_dl_q;
        if (drop_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (restart_s) begin
            state_d    = (|pending_d) ? StScan : StIdle;
            idx_d      = '0;
            best_vld_d = 1'b0;
            best_id_d  = '0;
            best_dl_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|pending_d) begin
                        state_d    = StScan;
                        idx_d      = '0;
                        best_vld_d = 1'b0;
                        best_id_d  = '0;
                        best_dl_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StScan: begin
                    if (idx_q == LastIdx) begin
                        valid_d = m_vld_s;
                        if (m_vld_s) begin
                            id_d = m_id_s;
                            dl_d = m_dl_s;
                        end else begin
                            id_d = id_q;
                        end
                        state_d    = (|pending_d) ? StScan : StIdle;
                        idx_d      = '0;
                        best_vld_d = 1'b0;
                        best_id_d  = '0;
                        best_dl_d  = '0;
                    end else begin
                        idx_d      = idx_q + IdWidth'(1);
                        best_vld_d = m_vld_s;
                        best_id_d  = m_id_s;
                        best_dl_d  = m_dl_s;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrParIrqs; i++) begin
                reldl_q[i] <= '0;
                absdl_q[i] <= '0;
            end
            en_q       <= '0;
            irq_q      <= '0;
            pending_q  <= '0;
            state_q    <= StIdle;
            idx_q      <= '0;
            best_vld_q <= 1'b0;
            best_id_q  <= '0;
            best_dl_q  <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            dl_q       <= '0;
        end else begin
            reldl_q    <= reldl_d;
            absdl_q    <= absdl_d;
            en_q       <= en_d;
            irq_q      <= irq_i;
            pending_q  <= pending_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_vld_q <= best_vld_d;
            best_id_q  <= best_id_d;
            best_dl_q  <= best_dl_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            dl_q       <= dl_d;
        end
    end

    assign irq_valid_o    = valid_q;
    assign irq_id_o       = id_q;
    assign irq_deadline_o = dl_q;
endmodule

// File: tb/tb_edf_irq_sched.sv
// Bench for edf_irq_sched: directed vector table, hand-written corner sequences
// and random traffic against an abstract pending/deadline model.
module tb_edf_irq_sched;
    localparam int N = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_req_i;
    logic [31:0] cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [63:0] mtime_i;
    logic [N-1:0] irq_i;
    logic        claim_i;
    logic        irq_valid_o;
    logic [1:0]  irq_id_o;
    logic [63:0] irq_deadline_o;

    int n_checks = 0;
    int n_errors = 0;

    edf_irq_sched #(.NrParIrqs(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_req_i(cfg_req_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .mtime_i(mtime_i), .irq_i(irq_i), .claim_i(claim_i),
        .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_deadline_o(irq_deadline_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: set of pending lines with absolute deadlines
    logic [31:0]  m_reldl [N];
    logic [63:0]  m_adl [N];
    logic [N-1:0] m_en, m_irq_q, m_pend;

    function automatic int model_winner();
        int w = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && (w < 0 || m_adl[i] < m_adl[w])) w = i;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_reldl[i] = 32'd0; m_adl[i] = 64'd0; end
        m_en = '0; m_irq_q = '0; m_pend = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] np;
        int w;
        np = m_pend;
        if (claim_i) begin
            w = model_winner();
            if (w >= 0) np[w] = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (irq_i[i] && !m_irq_q[i] && m_en[i] && !np[i]) begin
                np[i] = 1'b1;
                m_adl[i] = mtime_i + 64'(m_reldl[i]);
            end
        if (cfg_req_i) begin
            if (cfg_addr_i == 32'h100) begin
                m_en = cfg_wdata_i[N-1:0];
                np = np & m_en;
            end else if (cfg_addr_i < 32'(4 * N) && cfg_addr_i % 4 == 0) begin
                m_reldl[cfg_addr_i / 4] = cfg_wdata_i;
            end
        end
        m_irq_q = irq_i;
        m_pend = np;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        cfg_req_i = 1'b1; cfg_addr_i = addr; cfg_wdata_i = data;
        tick();
        cfg_req_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; irq_i = '0; claim_i = 1'b0; cfg_req_i = 1'b0;
        cfg_addr_i = 32'd0; cfg_wdata_i = 32'd0; mtime_i = 64'd0;
        model_reset();
        #3;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic ev, input int eid, input logic [63:0] edl);
        chk({nm, "_valid"}, 64'(irq_valid_o), 64'(ev));
        if (ev) begin
            chk({nm, "_id"}, 64'(irq_id_o), 64'(eid));
            chk({nm, "_dl"}, irq_deadline_o, edl);
        end
    endtask

    // Claim the presented line, expect valid low next cycle, then the next winner
    task automatic claim_check(input string nm, input logic ev, input int eid, input logic [63:0] edl);
        claim_i = 1'b1;
        tick();
        claim_i = 1'b0;
        chk({nm, "_drop"}, 64'(irq_valid_o), 64'd0);
        ticks(N);
        check_out(nm, ev, eid, edl);
    endtask

    task automatic program4(input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
        cfg_write(32'h0, r0); cfg_write(32'h4, r1); cfg_write(32'h8, r2); cfg_write(32'hC, r3);
        cfg_write(32'h100, 32'hF);
    endtask

    typedef struct packed {
        logic [3:0][31:0] rel;
        logic [63:0]      mt;
        logic [3:0]       lines;
        logic             ev;
        logic [1:0]       eid;
        logic [63:0]      edl;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int w;
        logic [63:0] wdl;

        vecs[0] = '{rel: {32'd10, 32'd200, 32'd50, 32'd100}, mt: 64'd1000, lines: 4'b0111,
                    ev: 1'b1, eid: 2'd1, edl: 64'd1050};
        vecs[1] = '{rel: {32'd5, 32'd5, 32'd5, 32'd5}, mt: 64'd0, lines: 4'b1111,
                    ev: 1'b1, eid: 2'd0, edl: 64'd5};
        vecs[2] = '{rel: {32'd0, 32'd0, 32'd0, 32'd16}, mt: 64'hFFFF_FFFF_FFFF_FFF8, lines: 4'b0001,
                    ev: 1'b1, eid: 2'd0, edl: 64'd8};
        vecs[3] = '{rel: {32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0}, mt: 64'h1_0000_0000, lines: 4'b1000,
                    ev: 1'b1, eid: 2'd3, edl: 64'h1_FFFF_FFFF};
        vecs[4] = '{rel: {32'd6, 32'd7, 32'd8, 32'd9}, mt: 64'd10, lines: 4'b0000,
                    ev: 1'b0, eid: 2'd0, edl: 64'd0};
        vecs[5] = '{rel: {32'd3, 32'd3, 32'd2, 32'd1}, mt: 64'd100, lines: 4'b1100,
                    ev: 1'b1, eid: 2'd2, edl: 64'd103};

        do_reset();
        chk("reset_valid", 64'(irq_valid_o), 64'd0);
        chk("reset_id", 64'(irq_id_o), 64'd0);
        chk("reset_dl", irq_deadline_o, 64'd0);

        // Vector table: one burst of edges, earliest publish after N+1 cycles
        for (int v = 0; v < 6; v++) begin
            do_reset();
            program4(vecs[v].rel[0], vecs[v].rel[1], vecs[v].rel[2], vecs[v].rel[3]);
            mtime_i = vecs[v].mt;
            irq_i = vecs[v].lines;
            ticks(N + 1);
            check_out($sformatf("vec%0d", v), vecs[v].ev, int'(vecs[v].eid), vecs[v].edl);
        end

        // Basic EDF chain with a tying late arrival on line 3
        do_reset();
        program4(32'd100, 32'd50, 32'd200, 32'd10);
        mtime_i = 64'd1000; irq_i = 4'b0111;
        ticks(2);
        mtime_i = 64'd1040; irq_i = 4'b1111;
        ticks(2 * N + 1);
        check_out("tie_hold", 1'b1, 1, 64'd1050);
        claim_check("late3", 1'b1, 3, 64'd1050);
        claim_check("edf0", 1'b1, 0, 64'd1100);
        claim_check("edf2", 1'b1, 2, 64'd1200);
        claim_check("edf_empty", 1'b0, 0, 64'd0);

        // Disabling the presented line
        do_reset();
        program4(32'd100, 32'd50, 32'd10, 32'd10);
        mtime_i = 64'd1000; irq_i = 4'b0111;
        ticks(N + 1);
        check_out("dis_pre", 1'b1, 2, 64'd1010);
        cfg_write(32'h100, 32'hB);
        chk("dis_drop", 64'(irq_valid_o), 64'd0);
        ticks(N);
        check_out("dis_resume", 1'b1, 1, 64'd1050);
        irq_i = 4'b0011; tick();
        irq_i = 4'b0111; tick();
        claim_check("dis_next", 1'b1, 0, 64'd1100);
        claim_check("dis_empty", 1'b0, 0, 64'd0);
        ticks(2 * N);
        chk("dis_never", 64'(irq_valid_o), 64'd0);

        // Claim and re-capture of the same line in one cycle
        do_reset();
        program4(32'd100, 32'd0, 32'd0, 32'd0);
        mtime_i = 64'd1000; irq_i = 4'b0001;
        ticks(N + 1);
        check_out("cc_pre", 1'b1, 0, 64'd1100);
        irq_i = 4'b0000; tick();
        mtime_i = 64'd2000; irq_i = 4'b0001;
        claim_check("cc_recap", 1'b1, 0, 64'd2100);

        // Wrap-around, ignored second edge and an unmapped write
        do_reset();
        program4(32'd16, 32'd0, 32'd0, 32'd0);
        mtime_i = 64'hFFFF_FFFF_FFFF_FFF8; irq_i = 4'b0001;
        ticks(N + 1);
        check_out("wrap", 1'b1, 0, 64'd8);
        irq_i = 4'b0000; tick();
        mtime_i = 64'd500; irq_i = 4'b0001; tick();
        cfg_write(32'h200, 32'h0);
        ticks(2 * N + 1);
        check_out("ignored", 1'b1, 0, 64'd8);

        // Asynchronous reset with three lines pending
        do_reset();
        program4(32'd30, 32'd20, 32'd10, 32'd0);
        mtime_i = 64'd100; irq_i = 4'b0111;
        ticks(N + 1);
        check_out("rst_pre", 1'b1, 2, 64'd110);
        ticks(2);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async_valid", 64'(irq_valid_o), 64'd0);
        chk("rst_async_id", 64'(irq_id_o), 64'd0);
        chk("rst_async_dl", irq_deadline_o, 64'd0);
        model_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        ticks(2 * N + 2);
        chk("rst_after", 64'(irq_valid_o), 64'd0);

        // Random traffic, checked once the sweep has settled and across claims
        do_reset();
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) cfg_write(32'(4 * i), $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
            cfg_write(32'h100, $urandom);
            for (int k = 0; k < 12; k++) begin
                irq_i = N'($urandom);
                mtime_i = {$urandom, $urandom};
                if ($urandom_range(0, 5) == 0) begin
                    cfg_req_i = 1'b1; cfg_addr_i = 32'h100; cfg_wdata_i = $urandom;
                end
                tick();
                cfg_req_i = 1'b0;
            end
            ticks(2 * N + 2);
            for (int c = 0; c < 5; c++) begin
                w = model_winner();
                wdl = (w >= 0) ? m_adl[w] : 64'd0;
                check_out($sformatf("rnd%0d_%0d", r, c), w >= 0, w, wdl);
                if (w < 0) break;
                claim_i = 1'b1;
                tick();
                claim_i = 1'b0;
                chk("rnd_drop", 64'(irq_valid_o), 64'd0);
                ticks(N);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
